// File: rtl/seg_pkg.sv
// Shared constants, segment lookup table and scan FSM state type for the
// multiplexed seven-segment display controller.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low patterns, entry n is hex digit n (bit6=g .. bit0=a).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup, purely combinational.
    always_comb begin
        seg = seg_decode(hex);
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scanner with a double-buffered display word
// that is swapped only at frame boundaries so a frame never shows mixed data.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_mask,
    output logic [6:0]              cathode_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    scan_state_t                      state_r;
    logic [IDX_W-1:0]                 index_r;
    logic [CNT_W-1:0]                 cnt_r;
    logic [NUM_DIGITS-1:0][3:0]       active_data_r;
    logic [NUM_DIGITS-1:0]            active_mask_r;
    logic [4*NUM_DIGITS-1:0]          pending_data_r;
    logic [NUM_DIGITS-1:0]            pending_mask_r;
    logic                             pending_full_r;
    logic [6:0]                       cathode_r;
    logic [NUM_DIGITS-1:0]            anode_r;
    logic                             frame_done_r;

    logic                             blank_done_s;
    logic                             show_done_s;
    logic                             frame_end_s;
    logic                             transfer_s;
    logic                             digit_enable_s;
    logic [3:0]                       nibble_s;
    logic [6:0]                       seg_s;
    logic [NUM_DIGITS-1:0]            anode_sel_s;

    hex_to_seg u_decode (
        .hex (nibble_s),
        .seg (seg_s)
    );

    // Slot timing, frame boundary and per-digit selection decode.
    always_comb begin
        blank_done_s   = (state_r == ST_BLANK) && (cnt_r == CNT_W'(BLANK_CYCLES - 1));
        show_done_s    = (state_r == ST_SHOW) && (cnt_r == CNT_W'(SHOW_CYCLES - 1));
        frame_end_s    = show_done_s && (index_r == IDX_W'(NUM_DIGITS - 1));
        transfer_s     = load_valid && !pending_full_r;
        digit_enable_s = active_mask_r[index_r];
        nibble_s       = active_data_r[index_r];
        anode_sel_s    = ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << index_r);
    end

    assign load_ready  = !pending_full_r;
    assign cathode_out = cathode_r;
    assign anode_out   = anode_r;
    assign frame_done  = frame_done_r;

    // Scan FSM with registered display outputs; outputs lag the state by one cycle.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_r      <= ST_BLANK;
            index_r      <= {IDX_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            cathode_r    <= SEG_BLANK;
            anode_r      <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            if ((state_r == ST_SHOW) && digit_enable_s) begin
                anode_r   <= anode_sel_s;
                cathode_r <= seg_s;
            end else begin
                anode_r   <= {NUM_DIGITS{1'b1}};
                cathode_r <= SEG_BLANK;
            end
            case (state_r)
                ST_BLANK: begin
                    if (blank_done_s) begin
                        state_r <= ST_SHOW;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (show_done_s) begin
                        state_r <= ST_BLANK;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (index_r == IDX_W'(NUM_DIGITS - 1)) begin
                            index_r <= {IDX_W{1'b0}};
                        end else begin
                            index_r <= index_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_BLANK;
                    cnt_r   <= {CNT_W{1'b0}};
                    index_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Double buffer: the swap at frame end wins; a load can only land while pending is empty.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            active_data_r  <= {(4 * NUM_DIGITS){1'b0}};
            active_mask_r  <= {NUM_DIGITS{1'b0}};
            pending_data_r <= {(4 * NUM_DIGITS){1'b0}};
            pending_mask_r <= {NUM_DIGITS{1'b0}};
            pending_full_r <= 1'b0;
        end else if (frame_end_s && pending_full_r) begin
            active_data_r  <= pending_data_r;
            active_mask_r  <= pending_mask_r;
            pending_full_r <= 1'b0;
        end else if (transfer_s) begin
            pending_data_r <= load_data;
            pending_mask_r <= load_mask;
            pending_full_r <= 1'b1;
        end else begin
            pending_full_r <= pending_full_r;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with an 8-digit, 4/2-cycle slot setup.
module tb_seg_scan_controller;

    localparam int FRAME = 48;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  mask;
    } word_t;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = 32'h0;
    logic [7:0]  load_mask = 8'h0;
    logic [6:0]  cathode_out;
    logic [7:0]  anode_out;
    logic        frame_done;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t exp_q[$];
    word_t cur = '0;
    word_t nxt;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_controller #(
        .NUM_DIGITS   (8),
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_mask   (load_mask),
        .cathode_out (cathode_out),
        .anode_out   (anode_out),
        .frame_done  (frame_done)
    );

    always #5 clock_in = ~clock_in;

    // Frame position j: digit j/6, first two cycles of each slot blank.
    function automatic logic [7:0] exp_anode(word_t w, int j);
        int dg = j / 6;
        if ((j % 6) < 2 || !w.mask[dg]) return 8'hFF;
        return ~(8'h01 << dg);
    endfunction

    function automatic logic [6:0] exp_cath(word_t w, int j);
        int dg = j / 6;
        logic [3:0] nib;
        if ((j % 6) < 2 || !w.mask[dg]) return 7'h7F;
        nib = w.data[dg*4 +: 4];
        return seg_ref[nib];
    endfunction

    task automatic drive_load(input logic [31:0] d, input logic [7:0] m);
        word_t w;
        load_valid = 1'b1;
        load_data  = d;
        load_mask  = m;
        w.data = d;
        w.mask = m;
        exp_q.push_back(w);
    endtask

    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock_in);
            cycles++;
        end while (frame_done !== 1'b1 && cycles < 200);
    endtask

    task automatic test_reset;
        #2 reset_in = 1'b1;
        #10;
        n_checks++;
        if (cathode_out !== 7'h7F || anode_out !== 8'hFF || frame_done !== 1'b0 || load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_values cathode=%h anode=%h fd=%b ready=%b expected 7f ff 0 1",
                     cathode_out, anode_out, frame_done, load_ready);
        end
        @(negedge clock_in);
        reset_in = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clock_in);
            n_checks++;
            if (anode_out !== 8'hFF || cathode_out !== 7'h7F || frame_done !== (j == FRAME - 1) || load_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_frame j=%0d anode=%h cathode=%h fd=%b ready=%b expected ff 7f %b 1",
                         j, anode_out, cathode_out, frame_done, load_ready, (j == FRAME - 1));
            end
        end
    endtask

    task automatic test_load_basic(input logic [31:0] d, input logic [7:0] m, input string name);
        int cyc;
        drive_load(d, m);
        @(negedge clock_in);
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_ready_low ready=%b expected 0", name, load_ready);
        end
        wait_frame(cyc);
        n_checks++;
        if (cyc != FRAME - 1 || load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_swap cycles=%0d ready=%b expected %0d 1", name, cyc, load_ready, FRAME - 1);
        end
        cur = exp_q.pop_front();
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clock_in);
            n_checks++;
            if (anode_out !== exp_anode(cur, j) || cathode_out !== exp_cath(cur, j) || frame_done !== (j == FRAME - 1)) begin
                n_errors++;
                $display("FAIL %s_scan j=%0d anode=%h cathode=%b fd=%b expected %h %b %b", name, j,
                         anode_out, cathode_out, frame_done, exp_anode(cur, j), exp_cath(cur, j), (j == FRAME - 1));
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        drive_load(32'h89ABCDEF, 8'hFF);
        cyc = 0;
        do begin
            @(negedge clock_in);
            cyc++;
            if (frame_done !== 1'b1) begin
                n_checks++;
                if (load_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_hold cyc=%0d ready=%b expected 0", cyc, load_ready);
                end
                load_data = $urandom;
                load_mask = 8'($urandom_range(0, 255));
            end
        end while (frame_done !== 1'b1 && cyc < 200);
        n_checks++;
        if (cyc != FRAME || load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_first_swap cycles=%0d ready=%b expected %0d 1", cyc, load_ready, FRAME);
        end
        cur = exp_q.pop_front();
        drive_load(32'hFEDCBA98, 8'hF0);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clock_in);
                load_valid = 1'b0;
                n_checks++;
                if (anode_out !== exp_anode(cur, j) || cathode_out !== exp_cath(cur, j) || frame_done !== (j == FRAME - 1)
                    || load_ready !== ((k == 1) || (j == FRAME - 1))) begin
                    n_errors++;
                    $display("FAIL b2b_scan k=%0d j=%0d anode=%h cathode=%b fd=%b ready=%b expected %h %b %b %b", k, j,
                             anode_out, cathode_out, frame_done, load_ready, exp_anode(cur, j), exp_cath(cur, j),
                             (j == FRAME - 1), ((k == 1) || (j == FRAME - 1)));
                end
            end
            if (k == 0) cur = exp_q.pop_front();
        end
    endtask

    task automatic test_edge_load;
        for (int i = 0; i < FRAME - 1; i++) @(negedge clock_in);
        drive_load(32'h5A5A0F0F, 8'hFF);
        @(negedge clock_in);
        load_valid = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1 || load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL edge_accept fd=%b ready=%b expected 1 0", frame_done, load_ready);
        end
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clock_in);
                n_checks++;
                if (anode_out !== exp_anode(cur, j) || cathode_out !== exp_cath(cur, j) || frame_done !== (j == FRAME - 1)
                    || load_ready !== ((k == 1) || (j == FRAME - 1))) begin
                    n_errors++;
                    $display("FAIL edge_scan k=%0d j=%0d anode=%h cathode=%b fd=%b ready=%b expected %h %b %b", k, j,
                             anode_out, cathode_out, frame_done, load_ready, exp_anode(cur, j), exp_cath(cur, j),
                             (j == FRAME - 1));
                end
            end
            if (k == 0) cur = exp_q.pop_front();
        end
    endtask

    task automatic test_reset_mid_show;
        for (int i = 0; i < 9; i++) @(negedge clock_in);
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        load_mask  = 8'hFF;
        @(negedge clock_in);
        n_checks++;
        if (anode_out !== exp_anode(cur, 9) || cathode_out !== exp_cath(cur, 9) || load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midshow_pre anode=%h cathode=%b ready=%b expected %h %b 0",
                     anode_out, cathode_out, load_ready, exp_anode(cur, 9), exp_cath(cur, 9));
        end
        #2 reset_in = 1'b1;
        #1;
        n_checks++;
        if (cathode_out !== 7'h7F || anode_out !== 8'hFF || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL midshow_async cathode=%h anode=%h ready=%b fd=%b expected 7f ff 1 0",
                     cathode_out, anode_out, load_ready, frame_done);
        end
        @(negedge clock_in);
        load_valid = 1'b0;
        @(negedge clock_in);
        reset_in = 1'b0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            @(negedge clock_in);
            n_checks++;
            if (anode_out !== 8'hFF || cathode_out !== 7'h7F || frame_done !== ((j % FRAME) == FRAME - 1) || load_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL midshow_restart j=%0d anode=%h cathode=%h fd=%b ready=%b expected ff 7f %b 1",
                         j, anode_out, cathode_out, frame_done, load_ready, ((j % FRAME) == FRAME - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic(32'h01234567, 8'hFF, "basic");
        test_back_to_back();
        test_load_basic(32'h13579BDF, 8'h0F, "mask");
        test_edge_load();
        test_reset_mid_show();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits.
REQ-002 SHALL have parameter SHOW_CYCLES, default 100000: clock cycles one digit is driven per slot.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: all-off cycles before each digit slot (anti-ghosting).
REQ-004 SHALL have port clock_in  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_valid  input  1  new display word offered.
REQ-007 SHALL have port load_ready  output  1  controller can accept a word.
REQ-008 SHALL have port load_data  input  4*NUM_DIGITS  hex nibbles; digit i in bits [4i+3:4i].
REQ-009 SHALL have port load_mask  input  NUM_DIGITS  per-digit enable; 1 = shown.
REQ-010 SHALL have port cathode_out  output  7  active-low segments, bit6=g to bit0=a.
REQ-011 SHALL have port anode_out  output  NUM_DIGITS  active-low digit selects; bit i = digit i.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-013 SHALL hold two buffers: active (data+mask, being displayed) and pending (data+mask+full flag).
REQ-014 SHALL drive load_ready = NOT pending_full; a transfer occurs on a rising edge with load_valid and load_ready both 1, writing pending and setting pending_full.
REQ-015 SHALL keep load_data/load_mask captured only on transfer; changes while load_ready=0 are ignored.
REQ-016 SHALL run FSM states BLANK and SHOW: BLANK lasts BLANK_CYCLES cycles then SHOW; SHOW lasts SHOW_CYCLES cycles then BLANK with digit index incremented.
REQ-017 SHALL wrap digit index from NUM_DIGITS-1 to 0; frame period = NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles.
REQ-018 SHALL pulse frame_done for one cycle on the SHOW-to-BLANK edge where index = NUM_DIGITS-1.
REQ-019 SHALL, on that same edge, copy pending to active and clear pending_full, but only if pending_full was set before the edge.
REQ-020 SHALL treat a transfer on the frame_done edge with pending previously empty as a normal load: it stays pending and is applied at the next frame end.
REQ-021 SHALL in BLANK drive cathode_out=7'b1111111 and anode_out all ones.
REQ-022 SHALL in SHOW drive anode_out low on bit index only if active mask[index]=1, else all ones; cathode_out = decoded active nibble[index] when enabled, else 7'b1111111.
REQ-023 SHALL keep masked-digit slots at full duration so frame period is mask-independent.
REQ-024 SHALL decode hex 0-F to: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-025 SHALL register cathode_out, anode_out and frame_done; outputs reflect the state one cycle after state entry.

Reset
REQ-026 SHALL on reset_in asynchronously set: state BLANK, index 0, counters 0, active data 0 and mask 0, pending_full 0.
REQ-027 SHALL on reset force cathode_out=7'b1111111, anode_out all ones, frame_done 0, load_ready 1.
REQ-028 SHALL, on reset asserted mid-SHOW or mid-transfer, discard the in-flight word and restart scanning at digit 0 after release.

Structure
REQ-029 SHALL place SEG_BLANK constant, the 16-entry segment table and the FSM state enum in shared package seg_pkg.
REQ-030 SHALL instantiate one combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) for decoding.

Verification (NUM_DIGITS=8, SHOW_CYCLES=4, BLANK_CYCLES=2, frame = 48 cycles)
REQ-031 SHALL test: reset, load 32'h01234567 mask 8'hFF -> after next frame_done, digit0 slot gives anode 8'hFE, cathode 1111000 for 4 cycles; digit1 gives 8'hFD, 0000010.
REQ-032 SHALL test: between any two slots -> anode 8'hFF and cathode 7'h7F for exactly 2 cycles.
REQ-033 SHALL test: two back-to-back loads -> load_ready low after first until the frame_done edge; display changes only at frame boundaries.
REQ-034 SHALL test: mask 8'h0F -> anode bits 7..4 never low, frame_done spacing still 48 cycles.
REQ-035 SHALL test: load accepted on the frame_done cycle with pending empty -> new data appears one frame (48 cycles) later.
REQ-036 SHALL test: reset_in pulsed mid-SHOW -> cathode 7'h7F, anode 8'hFF, load_ready 1 immediately, without waiting for a clock edge.
